title_screen_compositor: RTL and testbench

TITLE_SCREEN_COMPOSITOR -- requirements
Module: title_screen_compositor

---
 rtl/title_screen_compositor.sv | 173 +++++++++++++++++
 tb/tb_title_screen_compositor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/title_screen_compositor.sv
// Title-screen pixel compositor: blinking prompt over background, key-triggered exit to GAME.
// Optional macro TITLE_SCREEN_FADE_EN adds a 16-step fade-out state between TITLE and GAME.
module title_screen_compositor #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic       vga_clk,
    input  logic       Reset,
    input  logic       vs,
    input  logic       blank,
    input  logic       prompt_on,
    input  logic [3:0] prompt_red,
    input  logic [3:0] prompt_green,
    input  logic [3:0] prompt_blue,
    input  logic [3:0] bg_red,
    input  logic [3:0] bg_green,
    input  logic [3:0] bg_blue,
    input  logic [7:0] keycode,
    input  logic       key_valid,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       game_start,
    output logic       in_title
);

    typedef enum logic [1:0] {
        TITLE = 2'd0,
        FADE  = 2'd1,
        GAME  = 2'd2
    } state_t;

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    state_t     state_q, state_d;
    logic       vs_q;
    logic [7:0] blink_cnt_q, blink_cnt_d;
    logic       blink_vis_q, blink_vis_d;
    logic       game_start_q, game_start_d;
    logic [3:0] red_q, red_d;
    logic [3:0] green_q, green_d;
    logic [3:0] blue_q, blue_d;
    logic [3:0] sel_r, sel_g, sel_b;
    logic       frame_tick;
    logic       key_accept;

`ifdef TITLE_SCREEN_FADE_EN
    logic [3:0] level_q, level_d;

    // Darken by (15 - level), clamped at black rather than wrapping.
    function automatic logic [3:0] fade_chan(input logic [3:0] c, input logic [3:0] lvl);
        logic [3:0] sub;
        sub = 4'hF - lvl;
        return (c > sub) ? (c - sub) : '0;
    endfunction
`endif

    assign frame_tick = vs_q & ~vs;
    assign key_accept = key_valid && (keycode != 8'h00);

    always_comb begin
        state_d      = state_q;
        blink_cnt_d  = blink_cnt_q;
        blink_vis_d  = blink_vis_q;
        game_start_d = 1'b0;
        sel_r        = bg_red;
        sel_g        = bg_green;
        sel_b        = bg_blue;
`ifdef TITLE_SCREEN_FADE_EN
        level_d      = level_q;
`endif
        case (state_q)
            TITLE: begin
                // A key accept suppresses the blink update even on a frame tick.
                if (key_accept) begin
                    blink_cnt_d = '0;
`ifdef TITLE_SCREEN_FADE_EN
                    state_d = FADE;
                    level_d = 4'hF;
`else
                    state_d      = GAME;
                    game_start_d = 1'b1;
`endif
                end else if (frame_tick) begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_vis_d = ~blink_vis_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 8'd1;
                    end
                end
                if (prompt_on && blink_vis_q) begin
                    sel_r = prompt_red;
                    sel_g = prompt_green;
                    sel_b = prompt_blue;
                end
            end
`ifdef TITLE_SCREEN_FADE_EN
            FADE: begin
                if (frame_tick) begin
                    if (level_q == 4'd0) begin
                        state_d      = GAME;
                        game_start_d = 1'b1;
                    end else begin
                        level_d = level_q - 4'd1;
                    end
                end
                if (prompt_on) begin
                    sel_r = prompt_red;
                    sel_g = prompt_green;
                    sel_b = prompt_blue;
                end
                sel_r = fade_chan(sel_r, level_q);
                sel_g = fade_chan(sel_g, level_q);
                sel_b = fade_chan(sel_b, level_q);
            end
`endif
            GAME: begin
            end
            default: begin
                state_d = TITLE;
            end
        endcase

        if (blank) begin
            red_d   = sel_r;
            green_d = sel_g;
            blue_d  = sel_b;
        end else begin
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
        end
    end

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= TITLE;
            vs_q         <= 1'b1;
            blink_cnt_q  <= '0;
            blink_vis_q  <= 1'b1;
            game_start_q <= 1'b0;
            red_q        <= '0;
            green_q      <= '0;
            blue_q       <= '0;
        end else begin
            state_q      <= state_d;
            vs_q         <= vs;
            blink_cnt_q  <= blink_cnt_d;
            blink_vis_q  <= blink_vis_d;
            game_start_q <= game_start_d;
            red_q        <= red_d;
            green_q      <= green_d;
            blue_q       <= blue_d;
        end
    end

`ifdef TITLE_SCREEN_FADE_EN
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            level_q <= 4'hF;
        end else begin
            level_q <= level_d;
        end
    end
`endif

    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;
    assign game_start = game_start_q;
    assign in_title   = (state_q != GAME);

endmodule

// File: tb/tb_title_screen_compositor.sv
// Directed self-checking bench for title_screen_compositor (default BLINK_FRAMES = 30).
// Covers both builds: expectations follow TITLE_SCREEN_FADE_EN when it is defined.
module tb_title_screen_compositor;

    logic       vga_clk = 1'b0;
    logic       Reset;
    logic       vs;
    logic       blank;
    logic       prompt_on;
    logic [3:0] prompt_red, prompt_green, prompt_blue;
    logic [3:0] bg_red, bg_green, bg_blue;
    logic [7:0] keycode;
    logic       key_valid;
    logic [3:0] red, green, blue;
    logic       game_start;
    logic       in_title;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    title_screen_compositor #(.BLINK_FRAMES(30)) dut (
        .vga_clk      (vga_clk),
        .Reset        (Reset),
        .vs           (vs),
        .blank        (blank),
        .prompt_on    (prompt_on),
        .prompt_red   (prompt_red),
        .prompt_green (prompt_green),
        .prompt_blue  (prompt_blue),
        .bg_red       (bg_red),
        .bg_green     (bg_green),
        .bg_blue      (bg_blue),
        .keycode      (keycode),
        .key_valid    (key_valid),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .game_start   (game_start),
        .in_title     (in_title)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rgb();
        return 32'({red, green, blue});
    endfunction

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    // One vs falling edge: exactly one frame_tick inside the DUT.
    task automatic frame();
        vs = 1'b0;
        step();
        vs = 1'b1;
        step();
    endtask

    task automatic frames(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) frame();
    endtask

    task automatic set_prompt(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        prompt_red = r; prompt_green = g; prompt_blue = b;
    endtask

    task automatic set_bg(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        bg_red = r; bg_green = g; bg_blue = b;
    endtask

    initial begin
        Reset = 1'b1; vs = 1'b1; blank = 1'b1; prompt_on = 1'b1;
        set_prompt(4'hF, 4'hF, 4'hF);
        set_bg(4'h1, 4'h2, 4'h3);
        keycode = 8'h00; key_valid = 1'b0;
        step(); step();
        check("rst_rgb", rgb(), 32'h000);
        check("rst_in_title", 32'(in_title), 32'd1);
        check("rst_game_start", 32'(game_start), 32'd0);

        Reset = 1'b0;
        step();
        check("title_prompt", rgb(), 32'hFFF);
        frames(29);
        check("blink_29", rgb(), 32'hFFF);
        frame();
        check("blink_30", rgb(), 32'h123);
        frames(30);
        check("blink_60", rgb(), 32'hFFF);

        set_prompt(4'hF, 4'h0, 4'h0);
        blank = 1'b0;
        step();
        check("blank_title", rgb(), 32'h000);
        blank = 1'b1;
        step();
        check("prompt_f00", rgb(), 32'hF00);

        frames(29);
        key_valid = 1'b1; keycode = 8'h00;
        step();
        check("key_zero_in_title", 32'(in_title), 32'd1);
        check("key_zero_rgb", rgb(), 32'hF00);

        // Key accept coincides with the tick at blink count 29.
        keycode = 8'h28; vs = 1'b0;
        step();
        key_valid = 1'b0; keycode = 8'h00; vs = 1'b1;
        check("accept_rgb", rgb(), 32'hF00);
`ifdef TITLE_SCREEN_FADE_EN
        check("accept_in_title", 32'(in_title), 32'd1);
        check("accept_game_start", 32'(game_start), 32'd0);
        prompt_on = 1'b0;
        set_bg(4'h8, 4'h8, 4'h8);
        step();
        check("fade_l15", rgb(), 32'h888);
        blank = 1'b0;
        step();
        check("blank_fade", rgb(), 32'h000);
        blank = 1'b1;
        key_valid = 1'b1; keycode = 8'h28;
        frame();
        key_valid = 1'b0; keycode = 8'h00;
        check("fade_l14", rgb(), 32'h777);
        check("fade_key_ignored", 32'(in_title), 32'd1);
        frames(7);
        check("fade_l7", rgb(), 32'h000);
        frames(7);
        check("fade_l0", rgb(), 32'h000);
        check("fade_l0_in_title", 32'(in_title), 32'd1);
        vs = 1'b0;
        step();
        vs = 1'b1;
        check("start_pulse", 32'(game_start), 32'd1);
        check("start_in_title", 32'(in_title), 32'd0);
        prompt_on = 1'b1;
        step();
        check("start_one_cycle", 32'(game_start), 32'd0);
        check("game_bg", rgb(), 32'h888);
`else
        check("accept_in_title", 32'(in_title), 32'd0);
        check("accept_game_start", 32'(game_start), 32'd1);
        set_bg(4'h8, 4'h8, 4'h8);
        step();
        check("start_one_cycle", 32'(game_start), 32'd0);
        check("game_bg", rgb(), 32'h888);
`endif
        key_valid = 1'b1; keycode = 8'h28;
        frame();
        key_valid = 1'b0; keycode = 8'h00;
        check("game_key_in_title", 32'(in_title), 32'd0);
        check("game_key_start", 32'(game_start), 32'd0);
        check("game_key_rgb", rgb(), 32'h888);
        blank = 1'b0;
        step();
        check("blank_game", rgb(), 32'h000);
        blank = 1'b1;

        set_prompt(4'hF, 4'hF, 4'hF);
        set_bg(4'h1, 4'h2, 4'h3);
        Reset = 1'b1;
        #1;
        check("game_rst_rgb", rgb(), 32'h000);
        check("game_rst_in_title", 32'(in_title), 32'd1);
        check("game_rst_start", 32'(game_start), 32'd0);
        step();
        Reset = 1'b0;
        step();
        check("post_rst_start", 32'(game_start), 32'd0);
        check("post_rst_prompt", rgb(), 32'hFFF);
        frames(29);
        check("post_rst_blink_29", rgb(), 32'hFFF);
        frame();
        check("post_rst_blink_30", rgb(), 32'h123);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
